nco_sweep_ctrl: RTL and testbench
=================================

# nco_sweep_ctrl

Frequency-sweep sequencer that sits in front of the NCO core in the sine generator. It accepts a sweep configuration (start, stop and step phase increments, dwell length and mode) through a valid/ready handshake. After a start command it drives the NCO phase-increment input and clock enable, advancing the frequency after a fixed number of valid NCO output samples. It reports busy and done status, and it supports single, repeating-ramp and triangle sweeps.

## Interface
- PHI_W, 32, phase-increment width; matches the NCO `phi_inc_i`.
- DWELL_W, 16, width of the dwell counter.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  configuration word is presented.
- cfg_ready  out  1  block accepts configuration; high only in IDLE.
- cfg_start  in  PHI_W  first phase increment.
- cfg_stop  in  PHI_W  last phase increment (unsigned).
- cfg_step  in  PHI_W  increment delta per frequency point.
- cfg_dwell  in  DWELL_W  number of `nco_valid` samples per point; 0 is treated as 1.
- cfg_mode  in  2  0 = single ramp, 1 = repeating ramp, 2 = triangle, 3 = reserved (behaves as 0).
- start  in  1  single-cycle pulse that begins the sweep from ARMED.
- abort  in  1  single-cycle pulse; returns to IDLE from any state.
- nco_valid  in  1  NCO `out_valid`.
- phi_inc_o  out  PHI_W  to NCO `phi_inc_i`.
- nco_clken  out  1  to NCO `clken`.
- sweep_busy  out  1  high in ARMED and RUN.
- step_strobe  out  1  one-cycle pulse each time `phi_inc_o` changes during RUN.
- sweep_done  out  1  one-cycle pulse when a single sweep completes.

## Operation
- The FSM has four states: IDLE, ARMED, RUN and FINISH.
- IDLE:
  - `cfg_ready` = 1.
  - `cfg_valid` & `cfg_ready` latches all cfg_* fields, loads `phi_inc_o` ← `cfg_start` and moves to ARMED.
  - `start` in IDLE is ignored.
- ARMED:
  - `nco_clken` = 1, so the NCO runs at the start frequency.
  - `start` clears the dwell counter, sets direction to up and moves to RUN.
  - New `cfg_valid` is not accepted because `cfg_ready` = 0.
- RUN:
  - The dwell counter increments on each `nco_valid`.
  - A point is complete on the `nco_valid` that brings the count to `cfg_dwell` (or to 1 when `cfg_dwell` = 0). The counter then clears.
  - Up direction at point completion:
    - If `phi_inc_o` == stop: mode 0 goes to FINISH. Mode 1 reloads start. Mode 2 sets direction down and loads the stepped-down value, where stepped-down = `phi_inc_o` − step clamped to start, computed as a PHI_W+1-bit difference.
    - Otherwise load `phi_inc_o` + step, computed at PHI_W+1 bits. If there is a carry or the result exceeds stop, clamp to stop.
  - Down direction (mode 2 only) at point completion:
    - If `phi_inc_o` == start: set direction up and load the stepped-up value, clamped to stop.
    - Otherwise load `phi_inc_o` − step. If there is a borrow or the result is below start, clamp to start.
- FINISH:
  - Lasts one cycle: `sweep_done` = 1, then the FSM goes to IDLE.
  - `phi_inc_o` holds the stop value.
- Degenerate configurations:
  - start ≥ stop: the sweep is a single point at start. Mode 0 finishes after one dwell; modes 1/2 hold the point until abort.
  - step = 0: mode 0 finishes after the first dwell; modes 1/2 hold start until abort.
- abort: takes effect in any state the next cycle. The FSM goes to IDLE, `nco_clken` = 0, `phi_inc_o` is held, the dwell counter clears and no `sweep_done` is issued.
- Simultaneous events:
  - abort has priority over start and over point completion.
  - start and `nco_valid` in the same cycle in ARMED: that `nco_valid` is not counted.

## Timing
- Reset values:
  - FSM = IDLE, `cfg_ready` = 1, `phi_inc_o` = 0, `nco_clken` = 0.
  - `sweep_busy` = 0, `step_strobe` = 0, `sweep_done` = 0, dwell count = 0, direction = up.
- Asserting reset mid-sweep clears everything immediately.
- All outputs are registered.
- `phi_inc_o` changes on the clock edge after the completing `nco_valid`. `step_strobe` is high in that same cycle after the edge.
- Config accept to ARMED: 1 cycle. `nco_clken` rises in the first ARMED cycle.
- start to RUN: 1 cycle.
- The last completing `nco_valid` in mode 0 leads to `sweep_done` high on the next edge, then IDLE (`cfg_ready` = 1) one cycle later.
- `nco_clken` = 1 in ARMED, RUN and FINISH; 0 in IDLE.

## Test plan
- Reset: hold reset_n low with random inputs → `phi_inc_o` = 0, `nco_clken` = 0, `cfg_ready` = 1, no pulses.
- Mode 0 sweep: start = 100, stop = 130, step = 10, dwell = 3, with `nco_valid` every cycle.
  - `phi_inc_o` sequence is 100, 110, 120, 130, each held for 3 valids.
  - There are 3 `step_strobe` pulses, then one `sweep_done`, then IDLE.
- Clamp and wrap:
  - start = 0xFFFFFFF0, stop = 0xFFFFFFFF, step = 0x20, mode 0 → the second point is 0xFFFFFFFF (carry clamped), then done.
  - Mode 1 with start = 5, stop = 7, step = 1, dwell = 1 → sequence 5, 6, 7, 5, 6, … with no `sweep_done`.
- Triangle: start = 10, stop = 20, step = 4, dwell = 1, mode 2 → 10, 14, 18, 20, 16, 12, 10, 14, ….
- Abort and priority: assert abort in the same cycle as a completing `nco_valid` in RUN → next cycle IDLE, `phi_inc_o` unchanged, no strobe, no `sweep_done`.
- Degenerate cases: dwell = 0 advances on every valid. Step = 0 in mode 0 gives `sweep_done` after the first valid. `start` in IDLE and `cfg_valid` in ARMED are ignored.

Source files
------------

// File: rtl/nco_sweep_ctrl.sv
`timescale 1ns/1ps
// Frequency-sweep sequencer for the NCO: steps phi_inc_o from start to stop
// after a programmable number of valid NCO samples, in single, ramp or triangle mode.
module nco_sweep_ctrl #(
    parameter int PHI_W   = 32,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [PHI_W-1:0]   cfg_start,
    input  logic [PHI_W-1:0]   cfg_stop,
    input  logic [PHI_W-1:0]   cfg_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [1:0]         cfg_mode,
    input  logic               start,
    input  logic               abort,
    input  logic               nco_valid,
    output logic [PHI_W-1:0]   phi_inc_o,
    output logic               nco_clken,
    output logic               sweep_busy,
    output logic               step_strobe,
    output logic               sweep_done,
    output logic [1:0]         fsm_state
);

    // Handshake: a configuration transfers on a rising edge where cfg_valid && cfg_ready;
    // cfg_ready depends only on the FSM being in IDLE, never on cfg_valid.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMED  = 2'd1,
        S_RUN    = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t state;
    state_t state_nx;

    logic [PHI_W-1:0]   start_q;
    logic [PHI_W-1:0]   top_q;
    logic [PHI_W-1:0]   step_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [1:0]         mode_q;
    logic [DWELL_W-1:0] cnt_q;
    logic               dir_up_q;
    logic [PHI_W-1:0]   phi_q;

    logic [PHI_W:0]     sum_w;
    logic [PHI_W:0]     diff_w;
    logic [PHI_W-1:0]   up_val;
    logic [PHI_W-1:0]   down_val;
    logic [DWELL_W:0]   cnt_inc;
    logic               point_done;
    logic               at_top;
    logic               at_bottom;
    logic               mode_single;
    logic               finish_hit;
    logic [PHI_W-1:0]   phi_pt;
    logic               dir_pt;

    logic               ready_nx;
    logic               clken_nx;
    logic               busy_nx;
    logic               strobe_nx;
    logic               done_nx;

    // Extra top bit catches carry on step-up and borrow on step-down.
    assign sum_w    = {1'b0, phi_q} + {1'b0, step_q};
    assign diff_w   = {1'b0, phi_q} - {1'b0, step_q};
    assign up_val   = (sum_w[PHI_W] || (sum_w[PHI_W-1:0] > top_q)) ? top_q : sum_w[PHI_W-1:0];
    assign down_val = (diff_w[PHI_W] || (diff_w[PHI_W-1:0] < start_q)) ? start_q : diff_w[PHI_W-1:0];

    assign cnt_inc     = {1'b0, cnt_q} + {{DWELL_W{1'b0}}, 1'b1};
    assign point_done  = (state == S_RUN) && nco_valid && (cnt_inc == {1'b0, dwell_q});
    // A zero step can never reach the top, so it is treated as already being there.
    assign at_top      = (phi_q == top_q) || (step_q == '0);
    assign at_bottom   = (phi_q == start_q);
    assign mode_single = (mode_q == 2'd0) || (mode_q == 2'd3);
    assign finish_hit  = point_done && dir_up_q && at_top && mode_single;

    always_comb begin
        phi_pt = phi_q;
        dir_pt = dir_up_q;
        if (dir_up_q) begin
            if (at_top) begin
                if (mode_q == 2'd1) begin
                    phi_pt = start_q;
                end else if (mode_q == 2'd2) begin
                    dir_pt = 1'b0;
                    phi_pt = down_val;
                end
            end else begin
                phi_pt = up_val;
            end
        end else begin
            if (at_bottom) begin
                dir_pt = 1'b1;
                phi_pt = up_val;
            end else begin
                phi_pt = down_val;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (abort) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE:   if (cfg_valid) state_nx = S_ARMED;
                S_ARMED:  if (start) state_nx = S_RUN;
                S_RUN:    if (finish_hit) state_nx = S_FINISH;
                S_FINISH: state_nx = S_IDLE;
                default:  state_nx = S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they are flops, aligned with the state register.
    always_comb begin
        ready_nx  = (state_nx == S_IDLE);
        clken_nx  = (state_nx != S_IDLE);
        busy_nx   = (state_nx == S_ARMED) || (state_nx == S_RUN);
        done_nx   = (state_nx == S_FINISH);
        strobe_nx = !abort && point_done && !finish_hit && (phi_pt != phi_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_ready   <= 1'b1;
            nco_clken   <= 1'b0;
            sweep_busy  <= 1'b0;
            step_strobe <= 1'b0;
            sweep_done  <= 1'b0;
        end else begin
            cfg_ready   <= ready_nx;
            nco_clken   <= clken_nx;
            sweep_busy  <= busy_nx;
            step_strobe <= strobe_nx;
            sweep_done  <= done_nx;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            start_q  <= '0;
            top_q    <= '0;
            step_q   <= '0;
            dwell_q  <= '0;
            mode_q   <= 2'd0;
            cnt_q    <= '0;
            dir_up_q <= 1'b1;
            phi_q    <= '0;
        end else if (abort) begin
            cnt_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cfg_valid) begin
                        start_q <= cfg_start;
                        // start >= stop collapses the sweep to the single start point.
                        top_q   <= (cfg_stop < cfg_start) ? cfg_start : cfg_stop;
                        step_q  <= cfg_step;
                        dwell_q <= (cfg_dwell == '0) ? {{(DWELL_W-1){1'b0}}, 1'b1} : cfg_dwell;
                        mode_q  <= cfg_mode;
                        phi_q   <= cfg_start;
                        cnt_q   <= '0;
                    end
                end
                S_ARMED: begin
                    if (start) begin
                        cnt_q    <= '0;
                        dir_up_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (point_done) begin
                        cnt_q <= '0;
                        if (!finish_hit) begin
                            phi_q    <= phi_pt;
                            dir_up_q <= dir_pt;
                        end
                    end else if (nco_valid) begin
                        cnt_q <= cnt_inc[DWELL_W-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign phi_inc_o = phi_q;
    assign fsm_state = state;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for nco_sweep_ctrl: directed scenarios plus randomized sweeps
// compared cycle by cycle against a point-level arithmetic reference model.
module tb_nco_sweep_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_start;
    logic [31:0] cfg_stop;
    logic [31:0] cfg_step;
    logic [15:0] cfg_dwell;
    logic [1:0]  cfg_mode;
    logic        start;
    logic        abort;
    logic        nco_valid;
    logic [31:0] phi_inc_o;
    logic        nco_clken;
    logic        sweep_busy;
    logic        step_strobe;
    logic        sweep_done;
    logic [1:0]  fsm_state;

    int n_checks = 0;
    int n_fail   = 0;
    int n_strobe = 0;
    int n_done   = 0;

    logic [31:0] exp_q[$];
    bit          sb_on = 1'b0;

    // Reference model: phase 0 idle, 1 armed, 2 run, 3 finish.
    int     m_ph    = 0;
    longint m_phi   = 0;
    longint m_start = 0;
    longint m_top   = 0;
    longint m_step  = 0;
    int     m_dwell = 1;
    int     m_mode  = 0;
    int     m_cnt   = 0;
    bit     m_up    = 1'b1;
    bit     m_strobe = 1'b0;

    nco_sweep_ctrl #(.PHI_W(32), .DWELL_W(16)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_start   (cfg_start),
        .cfg_stop    (cfg_stop),
        .cfg_step    (cfg_step),
        .cfg_dwell   (cfg_dwell),
        .cfg_mode    (cfg_mode),
        .start       (start),
        .abort       (abort),
        .nco_valid   (nco_valid),
        .phi_inc_o   (phi_inc_o),
        .nco_clken   (nco_clken),
        .sweep_busy  (sweep_busy),
        .step_strobe (step_strobe),
        .sweep_done  (sweep_done),
        .fsm_state   (fsm_state)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint lmin(input longint a, input longint b);
        return (a < b) ? a : b;
    endfunction

    function automatic longint lmax(input longint a, input longint b);
        return (a > b) ? a : b;
    endfunction

    task automatic model_next_point();
        longint nxt;
        bit     fin;
        nxt = m_phi;
        fin = 1'b0;
        if (m_up) begin
            if (m_phi == m_top || m_step == 0) begin
                case (m_mode)
                    1: nxt = m_start;
                    2: begin
                        m_up = 1'b0;
                        nxt  = lmax(m_phi - m_step, m_start);
                    end
                    default: fin = 1'b1;
                endcase
            end else begin
                nxt = lmin(m_phi + m_step, m_top);
            end
        end else begin
            if (m_phi == m_start) begin
                m_up = 1'b1;
                nxt  = lmin(m_phi + m_step, m_top);
            end else begin
                nxt = lmax(m_phi - m_step, m_start);
            end
        end
        if (fin) begin
            m_ph = 3;
        end else begin
            if (nxt != m_phi) m_strobe = 1'b1;
            m_phi = nxt;
        end
    endtask

    task automatic model_update();
        m_strobe = 1'b0;
        if (!reset_n) begin
            m_ph  = 0;
            m_phi = 0;
            m_cnt = 0;
            m_up  = 1'b1;
        end else if (abort) begin
            m_ph  = 0;
            m_cnt = 0;
        end else begin
            case (m_ph)
                0: if (cfg_valid) begin
                    m_start = cfg_start;
                    m_top   = (cfg_stop > cfg_start) ? cfg_stop : cfg_start;
                    m_step  = cfg_step;
                    m_dwell = (cfg_dwell == 0) ? 1 : int'(cfg_dwell);
                    m_mode  = cfg_mode;
                    m_phi   = m_start;
                    m_ph    = 1;
                end
                1: if (start) begin
                    m_cnt = 0;
                    m_up  = 1'b1;
                    m_ph  = 2;
                end
                2: if (nco_valid) begin
                    m_cnt++;
                    if (m_cnt >= m_dwell) begin
                        m_cnt = 0;
                        model_next_point();
                    end
                end
                default: m_ph = 0;
            endcase
        end
    endtask

    task automatic compare_outputs();
        check("cfg_ready", cfg_ready, m_ph == 0);
        check("nco_clken", nco_clken, m_ph != 0);
        check("sweep_busy", sweep_busy, m_ph == 1 || m_ph == 2);
        check("step_strobe", step_strobe, m_strobe);
        check("sweep_done", sweep_done, m_ph == 3);
        check("phi_inc_o", phi_inc_o, m_phi);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        compare_outputs();
        if (step_strobe) n_strobe++;
        if (sweep_done) n_done++;
        if (sb_on && step_strobe) begin
            if (exp_q.size() == 0) check("sb_extra_strobe", 1, 0);
            else check("sb_point", phi_inc_o, exp_q.pop_front());
        end
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_cfg(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                            input logic [15:0] d, input logic [1:0] m);
        cfg_start = s;
        cfg_stop  = e;
        cfg_step  = st;
        cfg_dwell = d;
        cfg_mode  = m;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic run_idle(input int max_cycles, input string tag);
        int k;
        k = 0;
        while (m_ph != 0 && k < max_cycles) begin
            tick();
            k++;
        end
        check(tag, cfg_ready, 1);
    endtask

    task automatic clear_counts();
        n_strobe = 0;
        n_done   = 0;
    endtask

    initial begin
        logic [31:0] base;
        int          len;

        reset_n   = 1'b0;
        cfg_valid = 1'b0;
        cfg_start = '0;
        cfg_stop  = '0;
        cfg_step  = '0;
        cfg_dwell = '0;
        cfg_mode  = '0;
        start     = 1'b0;
        abort     = 1'b0;
        nco_valid = 1'b0;

        // Reset held with random inputs.
        for (int i = 0; i < 5; i++) begin
            cfg_valid = 1'($urandom_range(0, 1));
            start     = 1'($urandom_range(0, 1));
            abort     = 1'($urandom_range(0, 1));
            nco_valid = 1'($urandom_range(0, 1));
            cfg_start = $urandom;
            tick();
        end
        check("rst_phi", phi_inc_o, 0);
        check("rst_clken", nco_clken, 0);
        check("rst_ready", cfg_ready, 1);
        cfg_valid = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        nco_valid = 1'b0;
        reset_n   = 1'b1;
        run_n(2);

        // start in IDLE is ignored.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("idle_start_busy", sweep_busy, 0);
        check("idle_start_ready", cfg_ready, 1);

        // Mode 0 basic ramp.
        clear_counts();
        send_cfg(32'd100, 32'd130, 32'd10, 16'd3, 2'd0);
        check("armed_clken", nco_clken, 1);
        check("armed_ready", cfg_ready, 0);
        nco_valid = 1'b1;
        exp_q = {32'd110, 32'd120, 32'd130};
        sb_on = 1'b1;
        pulse_start();
        run_idle(100, "m0_idle");
        sb_on = 1'b0;
        check("m0_strobes", n_strobe, 3);
        check("m0_done", n_done, 1);
        check("m0_drain", exp_q.size(), 0);

        // Carry clamp at the top of the range.
        clear_counts();
        send_cfg(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 16'd1, 2'd0);
        exp_q = {32'hFFFF_FFFF};
        sb_on = 1'b1;
        pulse_start();
        run_idle(20, "clamp_idle");
        sb_on = 1'b0;
        check("clamp_done", n_done, 1);
        check("clamp_drain", exp_q.size(), 0);

        // Repeating ramp.
        clear_counts();
        send_cfg(32'd5, 32'd7, 32'd1, 16'd1, 2'd1);
        exp_q = {32'd6, 32'd7, 32'd5, 32'd6, 32'd7, 32'd5};
        sb_on = 1'b1;
        pulse_start();
        run_n(6);
        sb_on = 1'b0;
        check("m1_drain", exp_q.size(), 0);
        run_n(10);
        check("m1_no_done", n_done, 0);
        pulse_abort();

        // Triangle.
        clear_counts();
        send_cfg(32'd10, 32'd20, 32'd4, 16'd1, 2'd2);
        exp_q = {32'd14, 32'd18, 32'd20, 32'd16, 32'd12, 32'd10, 32'd14};
        sb_on = 1'b1;
        pulse_start();
        run_n(7);
        sb_on = 1'b0;
        check("tri_drain", exp_q.size(), 0);
        check("tri_no_done", n_done, 0);
        pulse_abort();

        // Abort on the completing nco_valid.
        clear_counts();
        send_cfg(32'd100, 32'd200, 32'd10, 16'd2, 2'd0);
        pulse_start();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_phi", phi_inc_o, 100);
        check("abort_ready", cfg_ready, 1);
        check("abort_clken", nco_clken, 0);
        check("abort_strobes", n_strobe, 0);
        run_n(3);
        check("abort_no_done", n_done, 0);

        // Reset asserted mid-sweep clears outputs immediately.
        send_cfg(32'd300, 32'd400, 32'd7, 16'd1, 2'd1);
        pulse_start();
        run_n(3);
        reset_n = 1'b0;
        #1;
        check("midrst_phi", phi_inc_o, 0);
        check("midrst_clken", nco_clken, 0);
        check("midrst_ready", cfg_ready, 1);
        tick();
        reset_n = 1'b1;
        tick();

        // Dwell 0 behaves as 1.
        clear_counts();
        send_cfg(32'd0, 32'd3, 32'd1, 16'd0, 2'd0);
        exp_q = {32'd1, 32'd2, 32'd3};
        sb_on = 1'b1;
        pulse_start();
        run_idle(20, "dw0_idle");
        sb_on = 1'b0;
        check("dw0_drain", exp_q.size(), 0);

        // Step 0 in mode 0 finishes after the first valid.
        clear_counts();
        send_cfg(32'd50, 32'd90, 32'd0, 16'd1, 2'd0);
        pulse_start();
        tick();
        check("step0_done", sweep_done, 1);
        check("step0_strobes", n_strobe, 0);
        run_idle(5, "step0_idle");

        // cfg_valid in ARMED is ignored.
        clear_counts();
        send_cfg(32'd100, 32'd130, 32'd10, 16'd1, 2'd0);
        send_cfg(32'd500, 32'd600, 32'd1, 16'd1, 2'd1);
        check("armed_cfg_phi", phi_inc_o, 100);
        exp_q = {32'd110, 32'd120, 32'd130};
        sb_on = 1'b1;
        pulse_start();
        run_idle(20, "armed_cfg_idle");
        sb_on = 1'b0;
        check("armed_cfg_drain", exp_q.size(), 0);

        // Randomized sweeps with random valids, stray commands and occasional abort.
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 3) == 0) base = 32'hFFFF_FF00 + $urandom_range(0, 250);
            else base = $urandom_range(0, 1000);
            nco_valid = 1'($urandom_range(0, 1));
            send_cfg(base, base + $urandom_range(0, 60), $urandom_range(0, 25),
                     16'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            len = $urandom_range(0, 3);
            for (int i = 0; i < len; i++) begin
                cfg_valid = 1'($urandom_range(0, 1));
                cfg_start = $urandom;
                nco_valid = 1'($urandom_range(0, 1));
                tick();
            end
            cfg_valid = 1'b0;
            nco_valid = 1'($urandom_range(0, 1));
            pulse_start();
            for (int i = 0; i < 120 && m_ph != 0; i++) begin
                nco_valid = ($urandom_range(0, 9) < 7);
                abort     = ($urandom_range(0, 59) == 0);
                start     = ($urandom_range(0, 19) == 0);
                tick();
            end
            start     = 1'b0;
            nco_valid = 1'b0;
            pulse_abort();
            check("rand_idle", cfg_ready, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
